// File: rtl/cos_seq_ctrl.sv
// cos_seq_ctrl: multi-cycle fixed-point cosine sequencer (result x10000, signed).
// Range-reduces the angle mod 360, folds it into 0..90 with a sign, converts to
// 1e-4 rad and sums the Taylor series one term per cycle on a single shared multiplier.
// Optional feature: define COS_SEQ_SIN_EN to add the sel_sin port (sine via a 270 deg shift).
module cos_seq_ctrl #(
    parameter int N_TERMS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        deg_in,
`ifdef COS_SEQ_SIN_EN
    input  logic               sel_sin,
`endif
    output logic               busy,
    output logic               done,
    output logic signed [15:0] cos_out
);

    typedef enum logic [2:0] {IDLE, RED, QUAD, RAD, SQ, TERM, OUT} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               ph_q, ph_d;
    logic [15:0]        d_q, d_d;
    logic               neg_q, neg_d;
    logic [15:0]        x_q, x_d;
    logic [31:0]        prod_q, prod_d;
    logic [15:0]        x2_q, x2_d;
    logic [15:0]        term_q, term_d;
    logic signed [16:0] acc_q, acc_d;
    logic [2:0]         k_q, k_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [15:0] cos_q, cos_d;
`ifdef COS_SEQ_SIN_EN
    logic               sin_q, sin_d;
`endif

    // (2k-1)(2k) * 10000 divisor for Taylor term k
    function automatic logic [31:0] term_den(input logic [2:0] k);
        case (k)
            3'd1:    term_den = 32'd20000;
            3'd2:    term_den = 32'd120000;
            3'd3:    term_den = 32'd300000;
            3'd4:    term_den = 32'd560000;
            default: term_den = 32'd900000;
        endcase
    endfunction

    // Clamp a 32-bit quotient to 16 bits; operand ranges keep it from ever clipping
    function automatic logic [15:0] sat16(input logic [31:0] v);
        sat16 = (|v[31:16]) ? 16'hFFFF : v[15:0];
    endfunction

    logic [31:0]        mul_a, mul_b, mul_p;
    logic [31:0]        rad_div, sq_div, term_div;
    logic [16:0]        red_lim;
    logic [15:0]        dq, r_val;
    logic               r_neg;
    logic signed [16:0] acc_neg;

    assign mul_p    = mul_a * mul_b;
    assign rad_div  = prod_q / 32'd1000;
    assign sq_div   = prod_q / 32'd10000;
    assign term_div = mul_p / term_den(k_q);
    assign red_lim  = 17'd360 << cnt_q;
    assign acc_neg  = -acc_q;

    // Operand select for the single shared multiplier
    always_comb begin
        mul_a = {16'd0, term_q};
        mul_b = {16'd0, x2_q};
        if (state_q == RAD) begin
            mul_a = {16'd0, x_q};
            mul_b = 32'd174533;
        end else if (state_q == SQ) begin
            mul_a = {16'd0, x_q};
            mul_b = {16'd0, x_q};
        end
    end

    // Optional sine shift then quadrant fold to r in 0..90 with result sign
    always_comb begin
        dq = d_q;
`ifdef COS_SEQ_SIN_EN
        if (sin_q) begin
            dq = d_q + 16'd270;
            if (dq >= 16'd360) dq = dq - 16'd360;
        end
`endif
        if (dq <= 16'd90) begin
            r_val = dq;             r_neg = 1'b0;
        end else if (dq <= 16'd180) begin
            r_val = 16'd180 - dq;   r_neg = 1'b1;
        end else if (dq <= 16'd270) begin
            r_val = dq - 16'd180;   r_neg = 1'b1;
        end else begin
            r_val = 16'd360 - dq;   r_neg = 1'b0;
        end
    end

    // Next-state and datapath updates for the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        d_d     = d_q;
        neg_d   = neg_q;
        x_d     = x_q;
        prod_d  = prod_q;
        x2_d    = x2_q;
        term_d  = term_q;
        acc_d   = acc_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cos_d   = cos_q;
`ifdef COS_SEQ_SIN_EN
        sin_d   = sin_q;
`endif
        case (state_q)
            IDLE: begin
                // done_q blocks a start presented in the done cycle
                if (start && !done_q) begin
                    d_d     = deg_in;
`ifdef COS_SEQ_SIN_EN
                    sin_d   = sel_sin;
`endif
                    cnt_d   = 3'd7;
                    busy_d  = 1'b1;
                    state_d = RED;
                end
            end
            RED: begin
                if ({1'b0, d_q} >= red_lim) d_d = d_q - red_lim[15:0];
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = QUAD;
            end
            QUAD: begin
                x_d     = r_val;
                neg_d   = r_neg;
                ph_d    = 1'b0;
                state_d = RAD;
            end
            RAD: begin
                // phase 0 multiplies, phase 1 divides the registered product
                if (!ph_q) begin
                    prod_d = mul_p;
                    ph_d   = 1'b1;
                end else begin
                    x_d     = sat16(rad_div);
                    ph_d    = 1'b0;
                    state_d = SQ;
                end
            end
            SQ: begin
                if (!ph_q) begin
                    prod_d = mul_p;
                    ph_d   = 1'b1;
                end else begin
                    x2_d    = sat16(sq_div);
                    term_d  = 16'd10000;
                    acc_d   = 17'sd10000;
                    k_d     = 3'd1;
                    ph_d    = 1'b0;
                    state_d = TERM;
                end
            end
            TERM: begin
                term_d = sat16(term_div);
                if (k_q[0]) acc_d = acc_q - $signed({1'b0, sat16(term_div)});
                else        acc_d = acc_q + $signed({1'b0, sat16(term_div)});
                k_d = k_q + 3'd1;
                if (int'(k_q) >= N_TERMS - 1) state_d = OUT;
            end
            OUT: begin
                cos_d   = neg_q ? acc_neg[15:0] : acc_q[15:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            d_q     <= '0;
            neg_q   <= 1'b0;
            x_q     <= '0;
            prod_q  <= '0;
            x2_q    <= '0;
            term_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cos_q   <= '0;
`ifdef COS_SEQ_SIN_EN
            sin_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            d_q     <= d_d;
            neg_q   <= neg_d;
            x_q     <= x_d;
            prod_q  <= prod_d;
            x2_q    <= x2_d;
            term_q  <= term_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cos_q   <= cos_d;
`ifdef COS_SEQ_SIN_EN
            sin_q   <= sin_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cos_out = cos_q;

endmodule

// File: tb/tb_cos_seq_ctrl.sv
// Directed bench for cos_seq_ctrl: exact latency, handshake, results, mid-op reset.
module tb_cos_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [15:0]        deg_in;
    logic               sel_sin;
    logic               busy;
    logic               done;
    logic signed [15:0] cos_out;
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    cos_seq_ctrl #(.N_TERMS(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .deg_in  (deg_in),
`ifdef COS_SEQ_SIN_EN
        .sel_sin (sel_sin),
`endif
        .busy    (busy),
        .done    (done),
        .cos_out (cos_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion: start sampled at edge T, done expected exactly at T+18.
    // Noise pulses on start/deg_in while busy, and a start in the done cycle, must be ignored.
    task automatic run_op(input string tag, input logic [15:0] deg, input logic sin,
                          input logic [15:0] exp);
        int bad;
        @(posedge clk); #1;
        start = 1'b1; deg_in = deg; sel_sin = sin;
        @(posedge clk); #1;
        chk({tag, "_busy_T"}, {31'd0, busy}, 32'd1);
        start = 1'b0;
        bad = 0;
        for (int i = 1; i < 18; i++) begin
            @(posedge clk); #1;
            if (done || !busy) bad++;
            deg_in  = 16'($urandom);
            sel_sin = ~sel_sin;
            if (i == 4) start = 1'b1;
            if (i == 6) start = 1'b0;
        end
        chk({tag, "_busy_window"}, bad, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cos"}, {16'd0, cos_out}, {16'd0, exp});
        start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done_cycle_start"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, {16'd0, cos_out}, {16'd0, exp});
        start = 1'b0;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; deg_in = 16'd0; sel_sin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {14'd0, busy, done, cos_out}, 32'd0);
        rst_n = 1'b1;

        run_op("deg0",     16'd0,     1'b0, 16'd10000);
        run_op("deg60",    16'd60,    1'b0, 16'd5000);
        run_op("deg120",   16'd120,   1'b0, 16'hEC78);
        run_op("deg90",    16'd90,    1'b0, 16'd1);
        run_op("deg180",   16'd180,   1'b0, 16'hD8F0);
        run_op("deg420",   16'd420,   1'b0, 16'd5000);
        run_op("deg65535", 16'd65535, 1'b0, 16'd9659);
        run_op("deg45",    16'd45,    1'b0, 16'd7072);
        run_op("deg240",   16'd240,   1'b0, 16'hEC78);
        run_op("deg300",   16'd300,   1'b0, 16'd5000);
        run_op("deg719",   16'd719,   1'b0, 16'd9999);

        // Mid-conversion reset at T+5: outputs clear at once, no done follows
        @(posedge clk); #1;
        start = 1'b1; deg_in = 16'd60;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {14'd0, busy, done, cos_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) bad++;
        end
        chk("midreset_no_done", bad, 32'd0);
        run_op("after_reset60", 16'd60, 1'b0, 16'd5000);

`ifdef COS_SEQ_SIN_EN
        run_op("sin30",  16'd30,  1'b1, 16'd5000);
        run_op("sin120", 16'd120, 1'b1, 16'd8661);
        run_op("cos60s", 16'd60,  1'b0, 16'd5000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
